// File: rtl/ground_scroller_if.sv
// Ground scroller signal bundle: frame strobe and game status in, scroll state out.
// Optional feature macro on the attached block: GROUND_SPEED_RAMP_EN.
interface ground_scroller_if #(
  parameter int POS_W  = 6,
  parameter int SPD_W  = 4,
  parameter int DIST_W = 16
);
  // Handshake: frame_tick is a one-cycle strobe with no ready/backpressure; the
  // scroller always accepts it. Outputs are registered and valid every cycle.
  logic              frame_tick;
  logic [1:0]        game_status;
  logic [POS_W-1:0]  ground_position;
  logic [SPD_W-1:0]  speed;
  logic [DIST_W-1:0] distance;
  logic              tile_wrap;
  logic [1:0]        state_dbg;

  modport master (
    output frame_tick, game_status,
    input  ground_position, speed, distance, tile_wrap, state_dbg
  );

  modport slave (
    input  frame_tick, game_status,
    output ground_position, speed, distance, tile_wrap, state_dbg
  );
endinterface

// File: rtl/ground_scroller.sv
// Endless-runner ground scroller: per-frame scroll offset, distance and wrap pulse.
// Define GROUND_SPEED_RAMP_EN to make speed step up every RAMP_PERIOD running frames.
module ground_scroller #(
  parameter int TILE_W      = 40,
  parameter int POS_W       = 6,
  parameter int SPD_W       = 4,
  parameter int SPEED_INIT  = 4,
  parameter int SPEED_MAX   = 12,
  parameter int RAMP_PERIOD = 600,
  parameter int DIST_W      = 16
) (
  input  logic              CLK,
  input  logic              RST,
  ground_scroller_if.slave  bus
);
  localparam int SUM_W     = POS_W + 1;
  localparam int DSUM_W    = DIST_W + 1;
  localparam int SPD_START = (SPEED_INIT > SPEED_MAX) ? SPEED_MAX : SPEED_INIT;

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, HALT = 2'd2} state_t;

  state_t             state, state_nx;
  logic [POS_W-1:0]   pos_q, pos_nx;
  logic [DIST_W-1:0]  dist_q, dist_nx;
  logic               wrap_q, wrap_nx;
  logic [SPD_W-1:0]   speed_q;
  logic               start, advance;
  logic               go_idle, go_run, go_halt;
  logic [SUM_W-1:0]   pos_sum;
  logic [DSUM_W-1:0]  dist_sum;

  // Status 3 is folded into game over by testing only the top bit.
  assign go_idle = (bus.game_status == 2'd0);
  assign go_run  = (bus.game_status == 2'd1);
  assign go_halt = bus.game_status[1];

  always_comb begin
    state_nx = state;
    start    = 1'b0;
    case (state)
      IDLE: if (go_run) begin
        state_nx = RUN;
        start    = 1'b1;
      end
      RUN: begin
        if (go_idle)      state_nx = IDLE;
        else if (go_halt) state_nx = HALT;
      end
      HALT: begin
        if (go_idle) state_nx = IDLE;
        else if (go_run) begin
          state_nx = RUN;
          start    = 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // A tick only moves the ground when RUN is kept; any transition swallows it.
  assign advance  = (state == RUN) && (state_nx == RUN) && bus.frame_tick;
  assign pos_sum  = {1'b0, pos_q} + SUM_W'(speed_q);
  assign dist_sum = {1'b0, dist_q} + DSUM_W'(speed_q);

  always_comb begin
    pos_nx  = pos_q;
    dist_nx = dist_q;
    wrap_nx = 1'b0;
    if (start) begin
      pos_nx  = '0;
      dist_nx = '0;
    end else if (advance) begin
      if (pos_sum >= SUM_W'(TILE_W)) begin
        pos_nx  = POS_W'(pos_sum - SUM_W'(TILE_W));
        wrap_nx = 1'b1;
      end else begin
        pos_nx  = POS_W'(pos_sum);
      end
      dist_nx = dist_sum[DIST_W] ? '1 : dist_sum[DIST_W-1:0];
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state  <= IDLE;
      pos_q  <= '0;
      dist_q <= '0;
      wrap_q <= 1'b0;
    end else begin
      state  <= state_nx;
      pos_q  <= pos_nx;
      dist_q <= dist_nx;
      wrap_q <= wrap_nx;
    end
  end

`ifdef GROUND_SPEED_RAMP_EN
  localparam int RAMP_W = (RAMP_PERIOD > 1) ? $clog2(RAMP_PERIOD) : 1;

  logic [RAMP_W-1:0] ramp_q, ramp_nx;
  logic [SPD_W-1:0]  speed_nx;

  // The new speed lands in the register, so it is used from the next tick on.
  always_comb begin
    ramp_nx  = ramp_q;
    speed_nx = speed_q;
    if (start) begin
      ramp_nx  = '0;
      speed_nx = SPD_W'(SPD_START);
    end else if (advance) begin
      if (ramp_q == RAMP_W'(RAMP_PERIOD - 1)) begin
        ramp_nx = '0;
        if (speed_q < SPD_W'(SPEED_MAX)) speed_nx = speed_q + 1'b1;
      end else begin
        ramp_nx = ramp_q + 1'b1;
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      ramp_q  <= '0;
      speed_q <= SPD_W'(SPD_START);
    end else begin
      ramp_q  <= ramp_nx;
      speed_q <= speed_nx;
    end
  end
`else
  assign speed_q = SPD_W'(SPD_START);
`endif

  assign bus.ground_position = pos_q;
  assign bus.distance        = dist_q;
  assign bus.tile_wrap       = wrap_q;
  assign bus.speed           = speed_q;
  assign bus.state_dbg       = state;
endmodule
